// File: rtl/fifo_pkg.sv
// Shared width helpers, parameter legality check and flag payload for the FWFT FIFO.
package fifo_pkg;

  typedef struct packed {
    logic wr_ready;
    logic almost_full;
    logic almost_empty;
    logic overflow;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RESET = '{
    wr_ready:     1'b0,
    almost_full:  1'b0,
    almost_empty: 1'b1,
    overflow:     1'b0
  };

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit params_legal(input int unsigned depth,
                                      input int unsigned skid,
                                      input int unsigned afull,
                                      input int unsigned aempty);
    bit pow2;
    pow2 = (depth >= 2) && ((depth & (depth - 1)) == 0);
    return pow2 && (skid < depth) && (afull <= depth) && (aempty <= depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM with a synchronous, reset-to-zero read register.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 512,
  localparam int unsigned ADDR_WIDTH = addr_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register holds its value when no read is issued; it is the FIFO head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_fwft.sv
// First-word-fall-through valid/ready FIFO with count, almost flags, flush and sticky overflow.
module fifo_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 512,
  parameter int unsigned FIFO_SKID    = 0,
  parameter int unsigned AFULL_LEVEL  = FIFO_DEPTH - 4,
  parameter int unsigned AEMPTY_LEVEL = 4,
  parameter bit          OVF_REPORT   = 1'b1,
  localparam int unsigned COUNT_WIDTH = count_width(FIFO_DEPTH)
) (
  input  logic                   clkIn,
  input  logic                   rstNIn,
  input  logic                   flushIn,
  input  logic [DATA_WIDTH-1:0]  wrDataIn,
  input  logic                   wrValidIn,
  output logic                   wrReadyOut,
  output logic [DATA_WIDTH-1:0]  rdDataOut,
  output logic                   rdValidOut,
  input  logic                   rdReadyIn,
  output logic [COUNT_WIDTH-1:0] countOut,
  output logic                   almostFullOut,
  output logic                   almostEmptyOut,
  output logic                   overflowOut
);

  localparam int unsigned ADDR_WIDTH = addr_width(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] DEPTH_C  = COUNT_WIDTH'(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] RDY_LIM  = COUNT_WIDTH'(FIFO_DEPTH - FIFO_SKID);
  localparam logic [COUNT_WIDTH-1:0] AFULL_C  = COUNT_WIDTH'(AFULL_LEVEL);
  localparam logic [COUNT_WIDTH-1:0] AEMPTY_C = COUNT_WIDTH'(AEMPTY_LEVEL);

  if (!params_legal(FIFO_DEPTH, FIFO_SKID, AFULL_LEVEL, AEMPTY_LEVEL)) begin : g_param_check
    $error("fifo_fwft: illegal parameter combination");
  end

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic                   rd_valid_q, rd_valid_d;
  fifo_flags_t            flags_q, flags_d;

  logic                   wr_en;
  logic                   rd_en;
  logic                   prefetch;
  logic                   ovf_hit;
  logic                   ovf_d;
  logic                   ram_we;
  logic                   ram_re;
  logic [COUNT_WIDTH-1:0] ram_cnt;

  // Handshake decode from registered state only.
  always_comb begin
    wr_en    = wrValidIn && (count_q < DEPTH_C);
    rd_en    = rdReadyIn && rd_valid_q;
    ovf_hit  = wrValidIn && (count_q == DEPTH_C);
    ram_cnt  = count_q - COUNT_WIDTH'(rd_valid_q);
    prefetch = (ram_cnt != '0) && (!rd_valid_q || rd_en);
  end

  // Next state; flush overrides every other update.
  always_comb begin
    count_d    = count_q + COUNT_WIDTH'(wr_en) - COUNT_WIDTH'(rd_en);
    wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(wr_en);
    rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(prefetch);
    rd_valid_d = prefetch | (rd_valid_q & ~rd_en);
    ovf_d      = flags_q.overflow | ovf_hit;
    ram_we     = wr_en;
    ram_re     = prefetch;
    if (flushIn) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      rd_valid_d = 1'b0;
      ovf_d      = 1'b0;
      ram_we     = 1'b0;
      ram_re     = 1'b0;
    end
    flags_d.wr_ready     = count_d < RDY_LIM;
    flags_d.almost_full  = count_d >= AFULL_C;
    flags_d.almost_empty = count_d <= AEMPTY_C;
    flags_d.overflow     = ovf_d;
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      flags_q    <= FLAGS_RESET;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
      flags_q    <= flags_d;
    end
  end

  if (OVF_REPORT) begin : g_ovf_report
    always_ff @(posedge clkIn) begin
      if (rstNIn && ovf_hit && !flushIn) begin
        $error("fifo_fwft: write dropped on full FIFO");
      end
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_ram (
    .clk_i     (clkIn),
    .rst_ni    (rstNIn),
    .wr_en_i   (ram_we),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wrDataIn),
    .rd_en_i   (ram_re),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rdDataOut)
  );

  assign rdValidOut     = rd_valid_q;
  assign countOut       = count_q;
  assign wrReadyOut     = flags_q.wr_ready;
  assign almostFullOut  = flags_q.almost_full;
  assign almostEmptyOut = flags_q.almost_empty;
  assign overflowOut    = flags_q.overflow;

endmodule
